// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding,
// the flush NOP word and the bubble-counter reload helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    FLUSH    = 2'd2,
    STALL    = 2'd3
  } state_e;

  // addi x0, x0, 0 -- what the pipeline registers load when flushed
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Reload value for the 3-bit bubble counter; the entry cycle is already one bubble.
  function automatic logic [2:0] reload_cnt(input int depth);
    logic [2:0] val;
    if (depth > 1) begin
      val = 3'(depth - 2);
    end else begin
      val = 3'd0;
    end
    return val;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc_i pulses, sticks at all-ones, clears on rst_i.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: step only while below the all-ones ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: post-reset bubbles, redirect flushes,
// load-use stalls and memory-wait freezes, plus saturating event counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_DEPTH      = 1,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int RST_BUBBLES      = 2,
  parameter int CNT_W            = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic             load_use_i,
  input  logic             mem_busy_i,
  output logic             pc_we_o,
  output logic             pc_sel_o,
  output logic [31:0]      redirect_pc_o,
  output logic             stall_if_id_o,
  output logic             stall_id_ex_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [2:0] RST_RELOAD   = 3'(RST_BUBBLES - 1);
  localparam logic [2:0] FLUSH_RELOAD = reload_cnt(FLUSH_DEPTH);
  localparam logic [2:0] STALL_RELOAD = reload_cnt(LOAD_USE_BUBBLES);
  localparam state_e     FLUSH_NEXT   = (FLUSH_DEPTH > 1) ? FLUSH : RUN;
  localparam state_e     STALL_NEXT   = (LOAD_USE_BUBBLES > 1) ? STALL : RUN;

  state_e      state_d, state_q;
  logic [2:0]  cnt_d, cnt_q;
  logic        pend_valid_d, pend_valid_q;
  logic [31:0] pend_pc_d, pend_pc_q;
  logic        redir_inc;
  logic        lu_inc;
  logic        take_redirect;

  assign take_redirect = redirect_i | pend_valid_q;

  // Next-state and Mealy control decode; priority is busy > redirect > load-use.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_valid_d  = pend_valid_q;
    pend_pc_d     = pend_pc_q;
    pc_we_o       = 1'b0;
    pc_sel_o      = 1'b0;
    redirect_pc_o = 32'h0000_0000;
    stall_if_id_o = 1'b0;
    stall_id_ex_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    redir_inc     = 1'b0;
    lu_inc        = 1'b0;
    if (rst_i || (state_q == RST_HOLD)) begin
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      if (cnt_q == 3'd0) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end else if (mem_busy_i) begin
      stall_if_id_o = 1'b1;
      stall_id_ex_o = 1'b1;
      // Only the most recent redirect seen while frozen survives.
      if (redirect_i) begin
        pend_pc_d    = redirect_pc_i;
        pend_valid_d = 1'b1;
      end else begin
        pend_pc_d    = pend_pc_q;
      end
    end else if (take_redirect) begin
      pc_we_o       = 1'b1;
      pc_sel_o      = 1'b1;
      redirect_pc_o = redirect_i ? redirect_pc_i : pend_pc_q;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
      pend_valid_d  = 1'b0;
      redir_inc     = 1'b1;
      state_d       = FLUSH_NEXT;
      cnt_d         = FLUSH_RELOAD;
    end else begin
      case (state_q)
        RUN: begin
          if (load_use_i) begin
            stall_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            lu_inc        = 1'b1;
            state_d       = STALL_NEXT;
            cnt_d         = STALL_RELOAD;
          end else begin
            pc_we_o       = 1'b1;
          end
        end
        FLUSH: begin
          pc_we_o       = 1'b1;
          flush_if_id_o = 1'b1;
          if (cnt_q == 3'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        STALL: begin
          stall_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          if (cnt_q == 3'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // FSM, bubble counter and pending-redirect registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= RST_HOLD;
      cnt_q        <= RST_RELOAD;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (redir_inc),
    .cnt_o (redirect_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (lu_inc),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with FLUSH_DEPTH=3,
// LOAD_USE_BUBBLES=2, RST_BUBBLES=2 and 4-bit counters.
module tb_pipe_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        load_use_i;
  logic        mem_busy_i;
  logic        pc_we_o;
  logic        pc_sel_o;
  logic [31:0] redirect_pc_o;
  logic        stall_if_id_o;
  logic        stall_id_ex_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic [3:0]  redirect_cnt_o;
  logic [3:0]  stall_cnt_o;

  int checks = 0;
  int errors = 0;
  int exp_rc = 0;
  int exp_sc = 0;

  // {pc_we, pc_sel, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex}
  logic [5:0] ctl;
  assign ctl = {pc_we_o, pc_sel_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o, flush_id_ex_o};

  localparam logic [5:0] C_RST   = 6'b000011;
  localparam logic [5:0] C_RUN   = 6'b100000;
  localparam logic [5:0] C_REDIR = 6'b110011;
  localparam logic [5:0] C_FLUSH = 6'b100010;
  localparam logic [5:0] C_STALL = 6'b001001;
  localparam logic [5:0] C_BUSY  = 6'b001100;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(
    .FLUSH_DEPTH      (3),
    .LOAD_USE_BUBBLES (2),
    .RST_BUBBLES      (2),
    .CNT_W            (4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .load_use_i     (load_use_i),
    .mem_busy_i     (mem_busy_i),
    .pc_we_o        (pc_we_o),
    .pc_sel_o       (pc_sel_o),
    .redirect_pc_o  (redirect_pc_o),
    .stall_if_id_o  (stall_if_id_o),
    .stall_id_ex_o  (stall_id_ex_o),
    .flush_if_id_o  (flush_if_id_o),
    .flush_id_ex_o  (flush_id_ex_o),
    .redirect_cnt_o (redirect_cnt_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  task automatic next_cycle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== C_RST) begin errors++; $display("FAIL rst_ctl: got %b want %b", ctl, C_RST); end
      checks++;
      if (redirect_pc_o !== 32'h0 || redirect_cnt_o !== 4'h0 || stall_cnt_o !== 4'h0) begin
        errors++; $display("FAIL rst_vals: pc %h rc %h sc %h want 0", redirect_pc_o, redirect_cnt_o, stall_cnt_o);
      end
      next_cycle();
    end
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== C_RST) begin errors++; $display("FAIL rst_hold_%0d: got %b want %b", i, ctl, C_RST); end
      next_cycle();
    end
    #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL rst_to_run: got %b want %b", ctl, C_RUN); end
  endtask

  task automatic test_redirect();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040;
    #1;
    checks++;
    if (ctl !== C_REDIR || redirect_pc_o !== 32'h40) begin
      errors++; $display("FAIL redir_c0: got %b/%h want %b/%h", ctl, redirect_pc_o, C_REDIR, 32'h40);
    end
    next_cycle();
    exp_rc++;
    redirect_i = 1'b0; redirect_pc_i = 32'h0;
    for (int i = 1; i <= 2; i++) begin
      #1;
      checks++;
      if (ctl !== C_FLUSH || redirect_pc_o !== 32'h0) begin
        errors++; $display("FAIL redir_c%0d: got %b/%h want %b/0", i, ctl, redirect_pc_o, C_FLUSH);
      end
      next_cycle();
    end
    #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL redir_c3: got %b want %b", ctl, C_RUN); end
    checks++;
    if (redirect_cnt_o !== 4'(exp_rc)) begin errors++; $display("FAIL redir_cnt: got %0d want %0d", redirect_cnt_o, exp_rc); end
  endtask

  task automatic test_redirect_load_use();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0080; load_use_i = 1'b1;
    #1;
    checks++;
    if (ctl !== C_REDIR || redirect_pc_o !== 32'h80) begin
      errors++; $display("FAIL rlu_c0: got %b/%h want %b/%h", ctl, redirect_pc_o, C_REDIR, 32'h80);
    end
    next_cycle();
    exp_rc++;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; load_use_i = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL rlu_run: got %b want %b", ctl, C_RUN); end
    checks++;
    if (stall_cnt_o !== 4'(exp_sc) || redirect_cnt_o !== 4'(exp_rc)) begin
      errors++; $display("FAIL rlu_cnt: sc %0d rc %0d want %0d %0d", stall_cnt_o, redirect_cnt_o, exp_sc, exp_rc);
    end
  endtask

  task automatic test_load_use();
    load_use_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== C_STALL) begin errors++; $display("FAIL lu_c%0d: got %b want %b", i, ctl, C_STALL); end
      next_cycle();
      if (i == 0) exp_sc++;
    end
    load_use_i = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin errors++; $display("FAIL lu_run: got %b want %b", ctl, C_RUN); end
    checks++;
    if (stall_cnt_o !== 4'(exp_sc)) begin errors++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt_o, exp_sc); end
  endtask

  task automatic test_mem_busy();
    mem_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      redirect_i    = (i == 1 || i == 2);
      redirect_pc_i = (i == 1) ? 32'h100 : ((i == 2) ? 32'h200 : 32'h0);
      #1;
      checks++;
      if (ctl !== C_BUSY || redirect_pc_o !== 32'h0) begin
        errors++; $display("FAIL busy_c%0d: got %b/%h want %b/0", i, ctl, redirect_pc_o, C_BUSY);
      end
      next_cycle();
    end
    mem_busy_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    #1;
    checks++;
    if (ctl !== C_REDIR || redirect_pc_o !== 32'h200) begin
      errors++; $display("FAIL busy_pend: got %b/%h want %b/%h", ctl, redirect_pc_o, C_REDIR, 32'h200);
    end
    checks++;
    if (redirect_cnt_o !== 4'(exp_rc)) begin errors++; $display("FAIL busy_hold_cnt: got %0d want %0d", redirect_cnt_o, exp_rc); end
    next_cycle();
    exp_rc++;
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (ctl !== C_RUN || redirect_cnt_o !== 4'(exp_rc)) begin
      errors++; $display("FAIL busy_end: got %b rc %0d want %b rc %0d", ctl, redirect_cnt_o, C_RUN, exp_rc);
    end
  endtask

  task automatic test_back_to_back();
    // redirect inside FLUSH restarts; redirect inside STALL aborts it
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300;
    next_cycle();
    exp_rc++;
    redirect_pc_i = 32'h0000_0304;
    #1;
    checks++;
    if (ctl !== C_REDIR || redirect_pc_o !== 32'h304) begin
      errors++; $display("FAIL b2b_restart: got %b/%h want %b/%h", ctl, redirect_pc_o, C_REDIR, 32'h304);
    end
    next_cycle();
    exp_rc++;
    redirect_i = 1'b0; redirect_pc_i = 32'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== C_FLUSH) begin errors++; $display("FAIL b2b_flush_%0d: got %b want %b", i, ctl, C_FLUSH); end
      next_cycle();
    end
    load_use_i = 1'b1;
    next_cycle();
    exp_sc++;
    load_use_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0400;
    #1;
    checks++;
    if (ctl !== C_REDIR || redirect_pc_o !== 32'h400) begin
      errors++; $display("FAIL stall_abort: got %b/%h want %b/%h", ctl, redirect_pc_o, C_REDIR, 32'h400);
    end
    next_cycle();
    exp_rc++;
    redirect_i = 1'b0; redirect_pc_i = 32'h0;
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if (ctl !== C_RUN || redirect_cnt_o !== 4'(exp_rc) || stall_cnt_o !== 4'(exp_sc)) begin
      errors++; $display("FAIL b2b_end: got %b rc %0d sc %0d want %b rc %0d sc %0d",
                         ctl, redirect_cnt_o, stall_cnt_o, C_RUN, exp_rc, exp_sc);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 20; k++) begin
      redirect_i = 1'b1; redirect_pc_i = 32'h1000 + 32'(k * 4);
      next_cycle();
      if (exp_rc < 15) exp_rc++;
      redirect_i = 1'b0; redirect_pc_i = 32'h0;
      #1;
      checks++;
      if (redirect_cnt_o !== 4'(exp_rc)) begin errors++; $display("FAIL sat_%0d: got %0d want %0d", k, redirect_cnt_o, exp_rc); end
      next_cycle();
      next_cycle();
      next_cycle();
    end
    #1;
    checks++;
    if (redirect_cnt_o !== 4'hF || ctl !== C_RUN) begin
      errors++; $display("FAIL sat_final: got %h/%b want f/%b", redirect_cnt_o, ctl, C_RUN);
    end
  endtask

  initial begin
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; load_use_i = 1'b0; mem_busy_i = 1'b0;
    next_cycle();
    test_reset();
    test_redirect();
    test_redirect_load_use();
    test_load_use();
    test_mem_busy();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
